// File: rtl/fifomem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifomem_arb_pkg
// Brief    : Shared types and width helpers for the FIFO write-port arbiter.
// Revision : 1.0  initial release
// ============================================================================
package fifomem_arb_pkg;

  // Arbiter states: waiting for any producer, or serving one producer's burst.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index/counter width for a range of n values; never narrower than one bit
  // so that degenerate ranges (n == 1) still yield a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifomem_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational cyclic priority search. Returns the first set bit
//            of valid at or after start, wrapping modulo NREQ.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick
  import fifomem_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   start,
  output logic            found,
  output logic [IW-1:0]   index
);

  // One extra bit so start + offset never overflows before the explicit
  // wrap; the wrap handles NREQ that is not a power of two.
  logic [IW:0]   w_cand;
  logic [IW-1:0] w_slot;

  // Walk the slots in cyclic order from start; the first valid one wins.
  always_comb begin
    found  = 1'b0;
    index  = '0;
    w_cand = '0;
    w_slot = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, start} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(NREQ)) begin
        w_cand = w_cand - (IW+1)'(NREQ);
      end
      w_slot = w_cand[IW-1:0];
      if (!found && valid[w_slot]) begin
        found = 1'b1;
        index = w_slot;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifomem_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifomem_wr_arbiter
// Brief    : Round-robin arbiter sharing the FIFO memory write port among
//            NREQ valid/ready producers, with bounded bursts and full gating.
// Revision : 1.0  initial release
// ============================================================================
module fifomem_wr_arbiter
  import fifomem_arb_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATASIZE-1:0] req_wdata,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic                     wclken,
  output logic [DATASIZE-1:0]      wdata,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy
);

  localparam int              c_IW        = idx_width(NREQ);
  localparam int              c_BW        = idx_width(MAXBURST);
  localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(MAXBURST - 1);
  localparam logic [c_IW-1:0] c_LAST_ID   = c_IW'(NREQ - 1);

  arb_state_t      r_state,     w_state_nxt;
  logic [c_IW-1:0] r_gnt_id,    w_gnt_id_nxt;
  logic [c_IW-1:0] r_rr_ptr,    w_rr_ptr_nxt;
  logic [c_BW-1:0] r_burst_cnt, w_burst_cnt_nxt;
  logic [NREQ-1:0] r_gnt,       w_gnt_nxt;

  logic            w_busy;
  logic            w_cur_valid;
  logic            w_accept;
  logic            w_release;
  logic            w_pick_found;
  logic [c_IW-1:0] w_after_id;
  logic [c_IW-1:0] w_pick_start;
  logic [c_IW-1:0] w_pick_idx;

  assign w_busy      = (r_state == GRANT);
  assign w_cur_valid = req_valid[r_gnt_id];
  assign w_accept    = w_busy & w_cur_valid & ~wfull;
  // A burst ends on its last beat or as soon as the owner stops presenting.
  assign w_release   = w_busy & ((w_accept & (r_burst_cnt == c_LAST_BEAT)) | ~w_cur_valid);
  assign w_after_id  = (r_gnt_id == c_LAST_ID) ? '0 : r_gnt_id + 1'b1;

  // One picker serves both paths: from IDLE it searches from the round-robin
  // pointer, while granted it searches from the slot after the current owner
  // so the releasing producer is considered last.
  assign w_pick_start = w_busy ? w_after_id : r_rr_ptr;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (c_IW)
  ) u_pick (
    .valid (req_valid),
    .start (w_pick_start),
    .found (w_pick_found),
    .index (w_pick_idx)
  );

  // Next-state logic: grant from IDLE, hand over or drop on release.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_id_nxt    = r_gnt_id;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_state_nxt     = GRANT;
          w_gnt_id_nxt    = w_pick_idx;
          w_burst_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_rr_ptr_nxt    = w_after_id;
          w_burst_cnt_nxt = '0;
          if (w_pick_found) begin
            w_gnt_id_nxt = w_pick_idx;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_accept) begin
          w_burst_cnt_nxt = r_burst_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // One-hot decode of the upcoming grant so gnt itself comes from a flop.
  always_comb begin
    w_gnt_nxt = '0;
    if (w_state_nxt == GRANT) begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_gnt_id_nxt == c_IW'(i)) begin
          w_gnt_nxt[i] = 1'b1;
        end
      end
    end
  end

  // State, owner, pointer, burst counter and grant registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state     <= IDLE;
      r_gnt_id    <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_gnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
    end
  end

  // Ready goes only to the owner, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_busy && (r_gnt_id == c_IW'(i))) begin
        req_ready[i] = ~wfull;
      end
    end
  end

  // Owner's data mux; held at zero while idle so the bus is quiet.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_busy && (r_gnt_id == c_IW'(i))) begin
        wdata = req_wdata[i*DATASIZE +: DATASIZE];
      end
    end
  end

  assign wclken = w_accept;
  assign gnt    = r_gnt;
  assign busy   = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifomem_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifomem_wr_arbiter
// Brief    : Self-checking bench: queue-based producers, a behavioural
//            round-robin model compared every cycle, and directed scenarios
//            with hand-computed expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifomem_wr_arbiter;

  localparam int DATASIZE = 8;
  localparam int NREQ     = 4;
  localparam int MAXBURST = 4;

  logic                     wclk = 1'b0;
  logic                     wrst_n = 1'b0;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ*DATASIZE-1:0] req_wdata;
  logic [NREQ-1:0]          req_ready;
  logic                     wfull;
  logic                     wclken;
  logic [DATASIZE-1:0]      wdata;
  logic [NREQ-1:0]          gnt;
  logic                     busy;

  fifomem_wr_arbiter #(
    .DATASIZE (DATASIZE),
    .NREQ     (NREQ),
    .MAXBURST (MAXBURST)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .wfull     (wfull),
    .wclken    (wclken),
    .wdata     (wdata),
    .gnt       (gnt),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: who owns the port, how many words it has written in
  // this burst, and where the next round-robin search starts.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_cnt   = 0;
  int m_ptr   = 0;

  // Producers: words waiting per source, and whether the head is on the bus.
  logic [7:0] q [NREQ][$];
  bit         pres [NREQ];

  bit   rand_mode  = 1'b0;
  int   gap_pct    = 0;
  int   full_pct   = 0;
  logic wfull_next = 1'b0;

  logic [7:0] wr_log [$];
  int         wr_cyc [$];
  logic [3:0] gnt_log [$];
  logic [3:0] prev_gnt = '0;
  int         cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_cnt   = 0;
    m_ptr   = 0;
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < NREQ; i++) begin
      if (q[i].size() != 0) return 1'b0;
    end
    return !m_busy;
  endfunction

  // Compare process: expected outputs follow from who owns the port and the
  // current inputs.
  logic [3:0] e_gnt, e_rdy;
  logic       e_wen, e_busy;
  always @(negedge wclk) begin
    cyc++;
    e_busy = wrst_n && m_busy;
    e_gnt  = e_busy ? 4'(1 << m_owner) : 4'b0000;
    e_rdy  = (e_busy && !wfull) ? e_gnt : 4'b0000;
    e_wen  = e_busy && req_valid[m_owner] && !wfull;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("wclken", 32'(wclken), 32'(e_wen));
    chk("busy", 32'(busy), 32'(e_busy));
    if (e_busy) chk("wdata", 32'(wdata), 32'(req_wdata[m_owner*8 +: 8]));
    if (wclken === 1'b1) begin
      wr_log.push_back(wdata);
      wr_cyc.push_back(cyc);
    end
    if (gnt !== prev_gnt && gnt !== 4'b0000) gnt_log.push_back(gnt);
    prev_gnt = gnt;
  end

  // Producers present queued words; a presented word stays until taken.
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (!pres[i] && q[i].size() > 0 &&
          (!rand_mode || int'($urandom_range(0, 99)) >= gap_pct)) pres[i] = 1'b1;
      req_valid[i] = pres[i];
      req_wdata[i*8 +: 8] = pres[i] ? q[i][0] : (rand_mode ? 8'($urandom) : 8'h00);
    end
    wfull = rand_mode ? (int'($urandom_range(0, 99)) < full_pct) : wfull_next;
  endtask

  // Advance one clock: update the model from the inputs seen at the edge,
  // retire accepted words, then present the next inputs.
  task automatic cycle();
    logic [3:0] v;
    logic       f;
    bit         acc;
    int         p;
    @(posedge wclk);
    v = req_valid;
    f = wfull;
    if (!wrst_n) begin
      model_reset();
    end else if (!m_busy) begin
      p = pick(v, m_ptr);
      if (p >= 0) begin
        m_busy  = 1'b1;
        m_owner = p;
        m_cnt   = 0;
      end
    end else begin
      acc = v[m_owner] && !f;
      if (acc) begin
        void'(q[m_owner].pop_front());
        pres[m_owner] = 1'b0;
      end
      if ((acc && m_cnt == MAXBURST - 1) || !v[m_owner]) begin
        m_ptr = (m_owner + 1) % NREQ;
        p = pick(v, m_ptr);
        m_cnt = 0;
        if (p >= 0) m_owner = p;
        else        m_busy  = 1'b0;
      end else if (acc) begin
        m_cnt++;
      end
    end
    #1;
    drive();
  endtask

  task automatic step();
    cycle();
    @(negedge wclk);
    #1;
  endtask

  // Called between edges; releases reset just after a rising edge.
  task automatic do_reset();
    wrst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    wrst_n = 1'b1;
    @(negedge wclk);
    #1;
  endtask

  task automatic drain(input int bound, input string name);
    int k;
    k = 0;
    while (!all_idle() && k < bound) begin
      step();
      k++;
    end
    chk(name, 32'(all_idle()), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_valid = '0;
    req_wdata = '0;
    wfull     = 1'b0;
    for (int i = 0; i < NREQ; i++) pres[i] = 1'b0;

    // Reset with every producer valid and wfull toggling randomly.
    rand_mode = 1'b1;
    gap_pct   = 0;
    full_pct  = 50;
    for (int i = 0; i < NREQ; i++) q[i].push_back(8'(8'hA0 + i));
    drive();
    step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wclken", 32'(wclken), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rand_mode  = 1'b0;
    wfull_next = 1'b0;
    cycle();
    wrst_n = 1'b1;
    @(negedge wclk);
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);
    step();
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("model_first_owner", 32'(m_owner), 32'd0);
    drain(100, "drain_reset");

    // Single producer streaming six words.
    do_reset();
    wr_log.delete();
    wr_cyc.delete();
    for (int k = 0; k < 6; k++) q[2].push_back(8'(8'h10 + k));
    step();
    chk("single_gnt_before", 32'(gnt), 32'h0);
    step();
    chk("single_gnt", 32'(gnt), 32'b0100);
    chk("single_first_wdata", 32'(wdata), 32'h10);
    drain(100, "drain_single");
    chk("single_count", 32'(wr_log.size()), 32'd6);
    for (int k = 0; k < 6 && k < wr_log.size(); k++) chk("single_word", 32'(wr_log[k]), 32'(8'h10 + k));
    if (wr_cyc.size() == 6) chk("single_back_to_back", 32'(wr_cyc[5] - wr_cyc[0]), 32'd5);
    chk("single_idle_after", 32'(busy), 32'h0);

    // Two producers alternating full-length bursts.
    do_reset();
    wr_log.delete();
    gnt_log.delete();
    for (int k = 0; k < 8; k++) begin
      q[0].push_back(8'(8'h00 + k));
      q[3].push_back(8'(8'h30 + k));
    end
    drain(100, "drain_two");
    chk("two_bursts", 32'(gnt_log.size()), 32'd4);
    for (int b = 0; b < 4 && b < gnt_log.size(); b++)
      chk("two_order", 32'(gnt_log[b]), (b % 2 == 0) ? 32'b0001 : 32'b1000);
    chk("two_count", 32'(wr_log.size()), 32'd16);
    for (int k = 0; k < 16 && k < wr_log.size(); k++)
      chk("two_word", 32'(wr_log[k]),
          32'((((k / 4) % 2 == 0) ? 8'h00 : 8'h30) + (k / 8) * 4 + (k % 4)));

    // wfull stall after the second word of a burst.
    do_reset();
    wfull_next = 1'b0;
    for (int k = 0; k < 4; k++) q[1].push_back(8'(8'h20 + k));
    step();
    step();
    chk("stall_w1", 32'(wdata), 32'h20);
    step();
    chk("stall_w2", 32'(wdata), 32'h21);
    wfull_next = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_wclken", 32'(wclken), 32'h0);
      chk("stall_ready", 32'(req_ready), 32'h0);
      chk("stall_gnt", 32'(gnt), 32'b0010);
    end
    wfull_next = 1'b0;
    wr_log.delete();
    drain(100, "drain_stall");
    chk("stall_after_count", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) chk("stall_after_last", 32'(wr_log[1]), 32'h23);

    // Early release: producer 1 has one word, producer 2 is waiting.
    do_reset();
    q[1].push_back(8'h31);
    q[2].push_back(8'h41);
    q[2].push_back(8'h42);
    step();
    step();
    chk("early_gnt1", 32'(gnt), 32'b0010);
    chk("early_w", 32'(wdata), 32'h31);
    step();
    chk("early_gap_gnt", 32'(gnt), 32'b0010);
    chk("early_gap_wclken", 32'(wclken), 32'h0);
    step();
    chk("early_gnt2", 32'(gnt), 32'b0100);
    chk("early_w2", 32'(wdata), 32'h41);
    drain(100, "drain_early");

    // Reset mid-burst, after the round-robin pointer has moved off zero.
    do_reset();
    q[2].push_back(8'h60);
    drain(100, "drain_pre_mid");
    for (int k = 0; k < 4; k++) q[0].push_back(8'(8'h50 + k));
    step();
    step();
    chk("mid_w1", 32'(wdata), 32'h50);
    step();
    chk("mid_w2", 32'(wdata), 32'h51);
    wrst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_wclken", 32'(wclken), 32'h0);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    q[3].push_back(8'h70);
    cycle();
    cycle();
    wrst_n = 1'b1;
    wr_log.delete();
    @(negedge wclk);
    #1;
    chk("mid_post_busy", 32'(busy), 32'h0);
    step();
    chk("mid_regrant", 32'(gnt), 32'b0001);
    chk("mid_represent", 32'(wdata), 32'h51);
    drain(100, "drain_mid");
    chk("mid_count", 32'(wr_log.size()), 32'd4);
    if (wr_log.size() == 4) chk("mid_last", 32'(wr_log[3]), 32'h70);

    // Randomised traffic with valid gaps and random full.
    do_reset();
    rand_mode = 1'b1;
    gap_pct   = 30;
    full_pct  = 25;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (q[i].size() < 4 && $urandom_range(0, 3) == 0) q[i].push_back(8'($urandom));
      end
      step();
    end
    drain(2000, "drain_random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
